// File: rtl/fft_pkg.sv
// Shared widths, state encodings and the byte-select helper for the FFT/UART frame controller.
package fft_pkg;

  localparam int WORD_SIZE   = 16;
  localparam int DATA_LENGTH = 8;
  localparam int FRACTION    = 8;
  localparam int STAGE       = 4;
  localparam int N_POINTS    = 2 ** STAGE;
  localparam int RES_WIDTH   = 2 * WORD_SIZE;

  typedef enum logic [2:0] {
    S_RX_LO    = 3'd0,
    S_RX_HI    = 3'd1,
    S_START    = 3'd2,
    S_WAIT_FFT = 3'd3,
    S_RD       = 3'd4,
    S_LATCH    = 3'd5,
    S_XMIT     = 3'd6
  } ctrl_state_t;

  typedef enum logic [1:0] {
    SER_IDLE  = 2'd0,
    S_TX      = 2'd1,
    S_TX_WAIT = 2'd2
  } ser_state_t;

  // Byte j of a result word laid out as {im, re}: re low, re high, im low, im high.
  function automatic logic [DATA_LENGTH-1:0] word_byte(input logic [RES_WIDTH-1:0] w,
                                                       input logic [1:0] j);
    case (j)
      2'd0:    word_byte = w[0 +: DATA_LENGTH];
      2'd1:    word_byte = w[DATA_LENGTH +: DATA_LENGTH];
      2'd2:    word_byte = w[2*DATA_LENGTH +: DATA_LENGTH];
      2'd3:    word_byte = w[3*DATA_LENGTH +: DATA_LENGTH];
      default: word_byte = {DATA_LENGTH{1'b0}};
    endcase
  endfunction

endpackage

// File: rtl/fft_uart_ctrl_tx_serializer.sv
// Splits one 32-bit result word into four UART TX byte handshakes.
module fft_tx_serializer
  import fft_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic [RES_WIDTH-1:0]   word,
  input  logic                   tx_done,
  output logic [DATA_LENGTH-1:0] tx_byte,
  output logic                   tx_start,
  output logic                   word_done
);

  ser_state_t             state_r, state_n;
  logic [RES_WIDTH-1:0]   word_r, word_n;
  logic [1:0]             j_r, j_n;
  logic [DATA_LENGTH-1:0] byte_r, byte_n;
  logic                   start_r, start_n;
  logic                   done_r, done_n;

  // Serializer state and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= SER_IDLE;
      word_r  <= {RES_WIDTH{1'b0}};
      j_r     <= 2'd0;
      byte_r  <= {DATA_LENGTH{1'b0}};
      start_r <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_n;
      word_r  <= word_n;
      j_r     <= j_n;
      byte_r  <= byte_n;
      start_r <= start_n;
      done_r  <= done_n;
    end
  end

  // Next-state logic; the TX byte only changes when a new start is issued.
  always_comb begin
    state_n = state_r;
    word_n  = word_r;
    j_n     = j_r;
    byte_n  = byte_r;
    start_n = 1'b0;
    done_n  = 1'b0;
    case (state_r)
      SER_IDLE: begin
        if (load) begin
          word_n  = word;
          j_n     = 2'd0;
          state_n = S_TX;
        end else begin
          state_n = SER_IDLE;
        end
      end
      S_TX: begin
        byte_n  = word_byte(word_r, j_r);
        start_n = 1'b1;
        state_n = S_TX_WAIT;
      end
      S_TX_WAIT: begin
        if (tx_done) begin
          if (j_r != 2'd3) begin
            j_n     = j_r + 2'd1;
            state_n = S_TX;
          end else begin
            done_n  = 1'b1;
            state_n = SER_IDLE;
          end
        end else begin
          state_n = S_TX_WAIT;
        end
      end
      default: state_n = SER_IDLE;
    endcase
  end

  assign tx_byte   = byte_r;
  assign tx_start  = start_r;
  assign word_done = done_r;

endmodule

// File: rtl/fft_uart_ctrl.sv
// Frame sequencer: UART RX samples -> FFT input buffer, start/await FFT, stream 16 results out on UART TX.
module fft_uart_ctrl
  import fft_pkg::*;
#(
  parameter int FFT_TIMEOUT = 4096
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [DATA_LENGTH-1:0] i_rx_byte,
  input  logic                   i_rx_valid,
  input  logic                   i_rx_error,
  output logic [STAGE-1:0]       o_smp_addr,
  output logic [WORD_SIZE-1:0]   o_smp_data,
  output logic                   o_smp_we,
  output logic                   o_fft_start,
  input  logic                   i_fft_done,
  output logic [STAGE-1:0]       o_res_addr,
  input  logic [WORD_SIZE-1:0]   i_res_re,
  input  logic [WORD_SIZE-1:0]   i_res_im,
  output logic [DATA_LENGTH-1:0] o_tx_byte,
  output logic                   o_tx_start,
  input  logic                   i_tx_done,
  output logic                   o_busy,
  output logic                   o_err
);

  localparam int TMO_W = $clog2(FFT_TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(FFT_TIMEOUT - 1);
  localparam logic [STAGE-1:0] LAST_IDX = STAGE'(N_POINTS - 1);

  ctrl_state_t            state_r, state_n;
  logic [STAGE-1:0]       k_r, k_n, b_r, b_n, smp_addr_r, smp_addr_n, res_addr_r, res_addr_n;
  logic [DATA_LENGTH-1:0] low_r, low_n;
  logic [WORD_SIZE-1:0]   smp_data_r, smp_data_n;
  logic [TMO_W-1:0]       tmo_r, tmo_n;
  logic                   smp_we_r, smp_we_n, start_r, start_n;
  logic                   err_r, err_n, busy_r, busy_n;
  logic                   ser_done;

  // Controller state and registered outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r    <= S_RX_LO;
      k_r        <= {STAGE{1'b0}};
      b_r        <= {STAGE{1'b0}};
      low_r      <= {DATA_LENGTH{1'b0}};
      smp_addr_r <= {STAGE{1'b0}};
      smp_data_r <= {WORD_SIZE{1'b0}};
      smp_we_r   <= 1'b0;
      start_r    <= 1'b0;
      tmo_r      <= {TMO_W{1'b0}};
      res_addr_r <= {STAGE{1'b0}};
      err_r      <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_n;
      k_r        <= k_n;
      b_r        <= b_n;
      low_r      <= low_n;
      smp_addr_r <= smp_addr_n;
      smp_data_r <= smp_data_n;
      smp_we_r   <= smp_we_n;
      start_r    <= start_n;
      tmo_r      <= tmo_n;
      res_addr_r <= res_addr_n;
      err_r      <= err_n;
      busy_r     <= busy_n;
    end
  end

  // Frame sequencing; the result address leads S_RD so read data is valid in S_LATCH.
  always_comb begin
    state_n    = state_r;
    k_n        = k_r;
    b_n        = b_r;
    low_n      = low_r;
    smp_addr_n = smp_addr_r;
    smp_data_n = smp_data_r;
    smp_we_n   = 1'b0;
    start_n    = 1'b0;
    tmo_n      = tmo_r;
    res_addr_n = res_addr_r;
    err_n      = 1'b0;
    busy_n     = busy_r;
    case (state_r)
      S_RX_LO: begin
        if (i_rx_error) begin
          k_n     = {STAGE{1'b0}};
          err_n   = 1'b1;
          state_n = S_RX_LO;
        end else if (i_rx_valid) begin
          low_n   = i_rx_byte;
          state_n = S_RX_HI;
        end else begin
          state_n = S_RX_LO;
        end
      end
      S_RX_HI: begin
        if (i_rx_error) begin
          k_n     = {STAGE{1'b0}};
          err_n   = 1'b1;
          state_n = S_RX_LO;
        end else if (i_rx_valid) begin
          smp_data_n = {i_rx_byte, low_r};
          smp_addr_n = k_r;
          smp_we_n   = 1'b1;
          if (k_r != LAST_IDX) begin
            k_n     = k_r + {{(STAGE-1){1'b0}}, 1'b1};
            state_n = S_RX_LO;
          end else begin
            state_n = S_START;
          end
        end else begin
          state_n = S_RX_HI;
        end
      end
      S_START: begin
        start_n = 1'b1;
        tmo_n   = {TMO_W{1'b0}};
        state_n = S_WAIT_FFT;
      end
      S_WAIT_FFT: begin
        if (i_fft_done) begin
          b_n        = {STAGE{1'b0}};
          res_addr_n = {STAGE{1'b0}};
          state_n    = S_RD;
        end else if (tmo_r == TMO_LAST) begin
          err_n   = 1'b1;
          k_n     = {STAGE{1'b0}};
          state_n = S_RX_LO;
        end else begin
          tmo_n = tmo_r + {{(TMO_W-1){1'b0}}, 1'b1};
        end
      end
      S_RD:    state_n = S_LATCH;
      S_LATCH: state_n = S_XMIT;
      S_XMIT: begin
        if (ser_done) begin
          if (b_r != LAST_IDX) begin
            b_n        = b_r + {{(STAGE-1){1'b0}}, 1'b1};
            res_addr_n = b_r + {{(STAGE-1){1'b0}}, 1'b1};
            state_n    = S_RD;
          end else begin
            k_n     = {STAGE{1'b0}};
            state_n = S_RX_LO;
          end
        end else begin
          state_n = S_XMIT;
        end
      end
      default: begin
        k_n     = {STAGE{1'b0}};
        state_n = S_RX_LO;
      end
    endcase
    busy_n = (state_n != S_RX_LO) || (k_n != {STAGE{1'b0}});
  end

  fft_tx_serializer u_ser (
    .clk       (i_clk),
    .rst       (i_rst),
    .load      (state_r == S_LATCH),
    .word      ({i_res_im, i_res_re}),
    .tx_done   (i_tx_done),
    .tx_byte   (o_tx_byte),
    .tx_start  (o_tx_start),
    .word_done (ser_done)
  );

  assign o_smp_addr  = smp_addr_r;
  assign o_smp_data  = smp_data_r;
  assign o_smp_we    = smp_we_r;
  assign o_fft_start = start_r;
  assign o_res_addr  = res_addr_r;
  assign o_busy      = busy_r;
  assign o_err       = err_r;

endmodule

// File: tb/tb_fft_uart_ctrl.sv
// Directed bench for fft_uart_ctrl with a mocked FFT result RAM and a scripted UART TX handshake.
module tb_fft_uart_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_byte = 8'h00;
  logic        rx_valid = 1'b0, rx_error = 1'b0;
  logic [3:0]  smp_addr, res_addr;
  logic [15:0] smp_data, res_re, res_im;
  logic        smp_we, fft_start, fft_done = 1'b0;
  logic [7:0]  tx_byte;
  logic        tx_start, tx_done = 1'b0, busy, err;

  int total = 0, bad = 0, cyc = 0;
  int start_cnt = 0, err_cnt = 0, txs_cnt = 0, done_cnt = 0;
  logic [15:0] frame[16], re_tab[16], im_tab[16];
  logic [3:0]  wr_addr_q[$];
  logic [15:0] wr_data_q[$];
  logic [7:0]  got[64];

  fft_uart_ctrl #(.FFT_TIMEOUT(4096)) dut (
    .i_clk(clk), .i_rst(rst), .i_rx_byte(rx_byte), .i_rx_valid(rx_valid), .i_rx_error(rx_error),
    .o_smp_addr(smp_addr), .o_smp_data(smp_data), .o_smp_we(smp_we), .o_fft_start(fft_start),
    .i_fft_done(fft_done), .o_res_addr(res_addr), .i_res_re(res_re), .i_res_im(res_im),
    .o_tx_byte(tx_byte), .o_tx_start(tx_start), .i_tx_done(tx_done), .o_busy(busy), .o_err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Result RAM model with one cycle of read latency.
  always @(posedge clk) begin
    res_re <= re_tab[res_addr];
    res_im <= im_tab[res_addr];
  end

  always @(negedge clk) begin
    if (smp_we) begin
      wr_addr_q.push_back(smp_addr);
      wr_data_q.push_back(smp_data);
    end
    if (fft_start) start_cnt <= start_cnt + 1;
    if (err)       err_cnt   <= err_cnt + 1;
    if (tx_start)  txs_cnt   <= txs_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] exp_byte(input int n);
    logic [31:0] w;
    w = {im_tab[n / 4], re_tab[n / 4]};
    return w[8 * (n % 4) +: 8];
  endfunction

  task automatic send_byte(input logic [7:0] b);
    rx_byte  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    tick();
  endtask

  task automatic send_frame();
    wr_addr_q.delete();
    wr_data_q.delete();
    for (int k = 0; k < 16; k++) begin
      send_byte(frame[k][7:0]);
      send_byte(frame[k][15:8]);
    end
  endtask

  task automatic check_writes();
    tick();
    check("wr_count", wr_addr_q.size(), 16);
    for (int i = 0; i < 16 && i < wr_addr_q.size(); i++) begin
      check("wr_addr", wr_addr_q[i], i);
      check("wr_data", wr_data_q[i], frame[i]);
    end
  endtask

  task automatic wait_fft_start();
    int w = 0;
    while (!fft_start && w < 20) begin
      tick();
      w++;
    end
    check("fft_start_seen", fft_start, 1);
  endtask

  task automatic give_done();
    fft_done = 1'b1;
    tick();
    fft_done = 1'b0;
  endtask

  task automatic collect_tx(input int nbytes, input int maxd, input bit inject);
    for (int n = 0; n < nbytes; n++) begin
      int w = 0;
      int d;
      bit stable;
      while (!tx_start && w < 400) begin
        tick();
        w++;
      end
      if (!tx_start) begin
        check("tx_start_timeout", 0, 1);
        return;
      end
      got[n] = tx_byte;
      stable = 1'b1;
      d = (maxd > 1) ? $urandom_range(maxd, 1) : 1;
      for (int c = 0; c < d; c++) begin
        rx_valid = inject && (c == 0);
        rx_byte  = 8'h5A;
        rx_error = inject && (c == 0) && (n % 8 == 3);
        fft_done = inject && (c == 0) && (n % 8 == 5);
        tick();
        if (tx_byte !== got[n]) stable = 1'b0;
      end
      rx_valid = 1'b0;
      rx_error = 1'b0;
      fft_done = 1'b0;
      check("tx_byte_stable", stable, 1);
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      done_cnt++;
      check("tx_byte", got[n], exp_byte(n));
    end
  endtask

  task automatic full_response(input int maxd, input bit inject);
    int t0, d0;
    t0 = txs_cnt;
    d0 = done_cnt;
    collect_tx(64, maxd, inject);
    repeat (4) tick();
    check("tx_start_per_done", txs_cnt - t0, done_cnt - d0);
    check("tx_total_bytes", done_cnt - d0, 64);
    check("idle_after_frame", busy, 0);
  endtask

  initial begin
    int s0, e0, t0;
    for (int i = 0; i < 16; i++) begin
      frame[i]  = 16'h0000;
      re_tab[i] = 16'h0100;
      im_tab[i] = 16'h0000;
    end
    repeat (3) tick();
    check("reset_outputs", {smp_addr, smp_data, smp_we, fft_start, res_addr, tx_byte, tx_start, busy, err}, 64'd0);
    rst = 1'b0;
    tick();
    check("idle_busy", busy, 0);

    // Impulse frame
    frame[0] = 16'h0100;
    s0 = start_cnt;
    send_frame();
    wait_fft_start();
    check_writes();
    check("one_fft_start", start_cnt - s0, 1);
    check("busy_in_wait", busy, 1);
    give_done();
    full_response(1, 1'b0);
    check("impulse_b0", got[0], 8'h00);
    check("impulse_b1", got[1], 8'h01);
    check("impulse_b63", got[63], 8'h00);

    // RX error after 7 bytes, then a clean frame with injections during wait and TX
    for (int i = 0; i < 7; i++) send_byte(8'h10 + 8'(i));
    e0 = err_cnt;
    rx_error = 1'b1;
    tick();
    rx_error = 1'b0;
    tick();
    check("rx_err_pulse", err_cnt - e0, 1);
    check("rx_err_idle", busy, 0);
    for (int i = 0; i < 16; i++) begin
      frame[i]  = 16'h1000 + 16'(i) * 16'h0111;
      re_tab[i] = 16'h1200 + 16'(i);
      im_tab[i] = 16'hA000 + 16'(i) * 16'h0011;
    end
    send_frame();
    wait_fft_start();
    check_writes();
    e0 = err_cnt;
    send_byte(8'h33);
    send_byte(8'h44);
    rx_error = 1'b1;
    tick();
    rx_error = 1'b0;
    tick();
    check("no_write_in_wait", wr_addr_q.size(), 16);
    check("no_err_in_wait", err_cnt - e0, 0);
    give_done();
    full_response(3, 1'b1);
    check("no_write_in_tx", wr_addr_q.size(), 16);
    check("no_err_in_tx", err_cnt - e0, 0);

    // FFT never completes
    send_frame();
    wait_fft_start();
    t0 = cyc;
    e0 = err_cnt;
    for (int w = 0; w < 5000 && !err; w++) tick();
    check("timeout_err", err, 1);
    check("timeout_cycles", cyc - t0, 4096);
    check("timeout_idle", busy, 0);
    tick();
    check("timeout_err_once", err_cnt - e0, 1);

    // Reset while TX is on byte 20
    for (int i = 0; i < 16; i++) begin
      frame[i]  = 16'hF00F ^ 16'(i);
      re_tab[i] = 16'hC000 + 16'(i) * 16'h0102;
      im_tab[i] = 16'h0F00 - 16'(i);
    end
    send_frame();
    wait_fft_start();
    check_writes();
    give_done();
    collect_tx(20, 2, 1'b0);
    for (int w = 0; w < 400 && !tx_start; w++) tick();
    check("byte20_start", tx_start, 1);
    rst = 1'b1;
    #1;
    check("midop_reset_outputs", {smp_addr, smp_data, smp_we, fft_start, res_addr, tx_byte, tx_start, busy, err}, 64'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("post_reset_idle", busy, 0);
    send_frame();
    wait_fft_start();
    check_writes();
    give_done();
    full_response(2, 1'b0);

    // Back-to-back frames with slow, random TX completion
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 16; i++) begin
        frame[i]  = 16'(f * 16'h0707) + 16'(i) * 16'h1111;
        re_tab[i] = 16'h8000 + 16'(f * 16) + 16'(i);
        im_tab[i] = 16'h7F00 - 16'(f * 16) - 16'(i);
      end
      send_frame();
      wait_fft_start();
      check_writes();
      give_done();
      full_response(200, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fft_uart_ctrl.md
Name: fft_uart_ctrl

Overview:
- Top-level sequencer between the UART pair and the 16-point FFT core.
- Receives one frame of 16 samples over UART RX and writes them into the FFT input buffer.
- Starts the transform, waits for completion, then reads the 16 complex results and streams them out over UART TX.
- Owns all frame-level handshaking. Neither the UARTs nor the FFT core contain any frame logic.

Parameters:
- WORD_SIZE, 16, sample and result word width (Q(WORD_SIZE-FRACTION).FRACTION, two's complement)
- DATA_LENGTH, 8, UART byte width; WORD_SIZE must equal 2*DATA_LENGTH
- STAGE, 4, log2 of the point count; N = 2**STAGE = 16
- FFT_TIMEOUT, 4096, maximum cycles to wait for i_fft_done

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  asynchronous reset, active-high
- i_rx_byte  in  DATA_LENGTH  received UART byte
- i_rx_valid  in  1  one-cycle strobe; i_rx_byte valid
- i_rx_error  in  1  one-cycle strobe; framing or stop-bit error
- o_smp_addr  out  STAGE  FFT input buffer write address
- o_smp_data  out  WORD_SIZE  FFT input sample
- o_smp_we  out  1  FFT input write enable, one cycle per sample
- o_fft_start  out  1  one-cycle start pulse to the FFT
- i_fft_done  in  1  one-cycle done pulse from the FFT
- o_res_addr  out  STAGE  FFT result read address
- i_res_re  in  WORD_SIZE  result real part; 1-cycle read latency
- i_res_im  in  WORD_SIZE  result imaginary part; 1-cycle read latency
- o_tx_byte  out  DATA_LENGTH  byte to UART TX
- o_tx_start  out  1  one-cycle start pulse to UART TX
- i_tx_done  in  1  one-cycle pulse; UART TX finished its byte
- o_busy  out  1  high whenever the block is not in S_RX_LO with a sample count of 0
- o_err  out  1  one-cycle pulse on a frame abort (RX error or FFT timeout)

Behaviour:
- Reset (asynchronous, active-high) forces every output to 0, the state to S_RX_LO, and all counters and holding registers to 0.
- Reset asserted mid-operation aborts immediately. No partial TX byte is re-sent after release.

Receive:
- Samples arrive little-endian: low byte, then high byte. Sample k (0..15) is written to o_smp_addr = k.
- S_RX_LO: on i_rx_valid, latch the byte as the low byte; go to S_RX_HI.
- S_RX_HI: on i_rx_valid, drive o_smp_data = {i_rx_byte, low} and o_smp_addr = k, and pulse o_smp_we for one cycle in the following cycle (registered).
  - If k < 15: increment k and return to S_RX_LO.
  - If k = 15: go to S_START.
- i_rx_error in S_RX_LO or S_RX_HI discards the whole frame: k := 0, o_err pulses, state S_RX_LO. Samples already written are left stale and are overwritten by the next frame.
- If i_rx_valid and i_rx_error are asserted in the same cycle, the error wins.

Transform:
- S_START: pulse o_fft_start for one cycle, clear the timeout counter, go to S_WAIT_FFT. The start pulse is never in the same cycle as the last o_smp_we.
- S_WAIT_FFT: on i_fft_done, set bin b := 0 and go to S_RD.
  - If the counter reaches FFT_TIMEOUT-1 without done: o_err pulses, state S_RX_LO, k := 0.

Result read and transmit:
- S_RD: drive o_res_addr = b, go to S_LATCH.
- S_LATCH: capture i_res_re and i_res_im into a 32-bit holding register, set byte index j := 0, go to S_TX.
- Byte order per bin: re[7:0], re[15:8], im[7:0], im[15:8].
- S_TX: drive o_tx_byte = byte j and pulse o_tx_start for one cycle; go to S_TX_WAIT. o_tx_byte is held stable until i_tx_done.
- S_TX_WAIT: on i_tx_done:
  - If j < 3: increment j, go to S_TX.
  - Else if b < 15: increment b, go to S_RD.
  - Else: go to S_RX_LO with k := 0.
- A frame is 64 output bytes; bins are sent in natural order 0..15.

Input during processing:
- i_rx_valid outside S_RX_LO and S_RX_HI is ignored (the byte is dropped). Not an error.
- i_rx_error outside S_RX_LO and S_RX_HI is ignored.
- A stray i_fft_done outside S_WAIT_FFT is ignored.
- i_tx_done outside S_TX_WAIT is ignored.

Decomposition:
- Shared package fft_pkg: WORD_SIZE, DATA_LENGTH, FRACTION, STAGE, N_POINTS, and the state encoding constants.
- One natural sub-module, fft_tx_serializer: takes a 32-bit word plus a load strobe and emits 4 byte-level start/done handshakes. The controller FSM keeps receive, transform and bin sequencing.

Test Plan:
- Impulse frame: samples 0x0100, 0x0000 x15 (32 bytes, low byte first).
  - Required: 16 writes with correct addr/data; one o_fft_start.
  - With a mocked FFT returning re = 0x0100, im = 0 for all bins: 64 TX bytes, repeating 00 01 00 00.
- RX error after 7 bytes:
  - Required: o_err pulses once; the next 32 clean bytes form a full frame with the first sample at addr 0.
- FFT never completes:
  - Required: o_err exactly FFT_TIMEOUT cycles after o_fft_start; o_busy falls; a new frame is accepted.
- RX bytes injected during S_WAIT_FFT and S_TX_WAIT:
  - Required: no o_smp_we; the output stream is unchanged.
- i_rst pulsed while TX is on byte 20 of 64:
  - Required: all outputs are 0 within the reset cycle; a fresh frame then yields a full 64-byte response.
- Back-to-back frames with i_tx_done delayed a random 1–200 cycles:
  - Required: exactly one o_tx_start per i_tx_done; o_tx_byte is stable between each start and its done.
